// File: rtl/btn_ctrl_pkg.sv
// Shared constants for the button controller array: FSM state encoding,
// default parameter values and a configuration range helper.
package btn_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PRESS   = 3'd1;
  localparam logic [2:0] ST_HELD    = 3'd2;
  localparam logic [2:0] ST_REPEAT  = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam int DEF_N_BTN        = 5;
  localparam int DEF_CNT_W        = 25;
  localparam int DEF_DEBOUNCE     = 5000;
  localparam int DEF_REPEAT_DELAY = 20000000;
  localparam int DEF_REPEAT_RATE  = 5000000;

  // True when value is at least 1 and representable in an unsigned width-bit counter.
  function automatic logic cfg_fits(input longint value, input int width);
    return (value >= 64'sd1) && (value <= ((64'sd1 <<< width) - 64'sd1));
  endfunction

endpackage

// File: rtl/btn_ctrl_array_chan.sv
// One button channel: two-flop synchroniser, debounce / auto-repeat FSM with
// a single shared counter, and registered pulse/level outputs.
module btn_chan
  import btn_ctrl_pkg::*;
#(
  parameter int   CNT_W        = DEF_CNT_W,
  parameter int   DEBOUNCE     = DEF_DEBOUNCE,
  parameter int   REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int   REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter logic REPEAT_ON    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_pulse,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] DB_END   = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] RD_END   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_END   = CNT_W'(REPEAT_RATE - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pulse_r;
  logic             level_r;

  logic [2:0]       state_s;
  logic [CNT_W-1:0] cnt_s;
  logic             pulse_s;
  logic             level_s;

  // Two-flop synchroniser for the raw asynchronous button level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  // Next-state logic; the counter means debounce time or repeat time depending on state.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pulse_s = 1'b0;
    level_s = level_r;
    case (state_r)
      ST_IDLE: begin
        if (sync2_r) begin
          state_s = ST_PRESS;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      ST_PRESS: begin
        if (!sync2_r) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == DB_END) begin
          state_s = ST_HELD;
          cnt_s   = CNT_ZERO;
          pulse_s = 1'b1;
          level_s = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!sync2_r) begin
          state_s = ST_RELEASE;
          cnt_s   = CNT_ONE;
        end else if (!REPEAT_ON) begin
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == RD_END) begin
          state_s = ST_REPEAT;
          cnt_s   = CNT_ZERO;
          pulse_s = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_REPEAT: begin
        if (!sync2_r) begin
          state_s = ST_RELEASE;
          cnt_s   = CNT_ONE;
        end else if (cnt_r == RR_END) begin
          cnt_s   = CNT_ZERO;
          pulse_s = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        // A bounce back high resumes holding without a fresh press pulse.
        if (sync2_r) begin
          state_s = ST_HELD;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == DB_END) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          level_s = 1'b0;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        level_s = 1'b0;
      end
    endcase
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      pulse_r <= 1'b0;
      level_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pulse_r <= pulse_s;
      level_r <= level_s;
    end
  end

  assign btn_pulse = pulse_r;
  assign btn_level = level_r;

endmodule

// File: rtl/btn_ctrl_array.sv
// Array of independent debounced, auto-repeating button channels; btn_any
// is the OR of the registered per-channel pulses.
module btn_ctrl_array
  import btn_ctrl_pkg::*;
#(
  parameter int               N_BTN        = DEF_N_BTN,
  parameter int               CNT_W        = DEF_CNT_W,
  parameter int               DEBOUNCE     = DEF_DEBOUNCE,
  parameter int               REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int               REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter logic [N_BTN-1:0] REPEAT_EN    = {N_BTN{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level,
  output logic             btn_any
);

  // Counters must never wrap, so every terminal count has to fit in CNT_W bits.
  if (!cfg_fits(longint'(DEBOUNCE), CNT_W) ||
      !cfg_fits(longint'(REPEAT_DELAY), CNT_W) ||
      !cfg_fits(longint'(REPEAT_RATE), CNT_W)) begin : g_cfg_error
    $error("btn_ctrl_array: DEBOUNCE/REPEAT_DELAY/REPEAT_RATE must be in 1..2**CNT_W-1");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .CNT_W       (CNT_W),
      .DEBOUNCE    (DEBOUNCE),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_ON   (REPEAT_EN[i])
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .btn_in   (btn_in[i]),
      .btn_pulse(btn_pulse[i]),
      .btn_level(btn_level[i])
    );
  end

  assign btn_any = |btn_pulse;

endmodule

// File: tb/tb_btn_ctrl_array.sv
// Self-checking bench for btn_ctrl_array: table vectors, directed corner
// sequences and randomized stimulus against a run-length reference model.
module tb_btn_ctrl_array;

  localparam int         NB = 2;
  localparam int         DB = 4;
  localparam int         RD = 10;
  localparam int         RR = 3;
  localparam logic [1:0] EN = 2'b01;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_level;
  logic          btn_any;

  int checks   = 0;
  int failures = 0;

  // Reference model: synchroniser delay line plus run lengths of the synchronised level.
  logic [NB-1:0] m_s1, m_s2, m_pulse, m_level;
  int            m_run [NB];
  int            m_low [NB];
  int            m_t   [NB];

  typedef struct {
    logic [1:0] b;
    logic       r;
    logic [1:0] ep;
    logic [1:0] el;
    logic       ea;
  } vec_t;

  vec_t tbl [12];
  int   q0[$];
  int   q1[$];
  int   exp_q0 [6];
  logic seen_pulse, seen_level;

  always #5 clk = ~clk;

  btn_ctrl_array #(
    .N_BTN       (NB),
    .CNT_W       (8),
    .DEBOUNCE    (DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .REPEAT_EN   (EN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level),
    .btn_any  (btn_any)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [NB-1:0] b, input logic r);
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_pulse = '0; m_level = '0;
      for (int i = 0; i < NB; i++) begin
        m_run[i] = 0; m_low[i] = 0; m_t[i] = 0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        m_pulse[i] = 1'b0;
        if (!m_level[i]) begin
          if (m_s2[i]) begin
            m_run[i]++;
            // The press is accepted on the (DB+1)-th consecutive high sample.
            if (m_run[i] == DB + 1) begin
              m_level[i] = 1'b1; m_pulse[i] = 1'b1;
              m_run[i] = 0; m_low[i] = 0; m_t[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end else if (!m_s2[i]) begin
          m_low[i]++;
          if (m_low[i] == DB + 1) begin
            m_level[i] = 1'b0; m_low[i] = 0; m_run[i] = 0;
          end
        end else if (m_low[i] > 0) begin
          m_low[i] = 0; m_t[i] = 0;
        end else begin
          m_t[i]++;
          if (EN[i] && (m_t[i] == RD || (m_t[i] > RD && (m_t[i] - RD) % RR == 0)))
            m_pulse[i] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic step(input logic [NB-1:0] b, input logic r, input string name);
    btn_in = b;
    reset  = r;
    @(posedge clk);
    model_step(b, r);
    #1;
    check({name, " pulse"}, 32'(btn_pulse), 32'(m_pulse));
    check({name, " level"}, 32'(btn_level), 32'(m_level));
    check({name, " any"},   32'(btn_any),   32'(|m_pulse));
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, "idle");
  endtask

  initial begin
    btn_in = '0;
    reset  = 1'b1;
    step(2'b00, 1'b1, "reset");
    step(2'b11, 1'b1, "reset held");
    check("reset pulse", 32'(btn_pulse), 32'd0);
    check("reset level", 32'(btn_level), 32'd0);
    check("reset any",   32'(btn_any),   32'd0);
    step(2'b00, 1'b1, "reset");
    go_idle(2);

    // Both buttons from row 0: simultaneous acceptance after row 6.
    for (int i = 0; i < 12; i++) begin
      tbl[i].b  = 2'b11;
      tbl[i].r  = 1'b0;
      tbl[i].ep = (i == 6) ? 2'b11 : 2'b00;
      tbl[i].el = (i >= 6) ? 2'b11 : 2'b00;
      tbl[i].ea = (i == 6);
    end
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].b, tbl[i].r, "table");
      check($sformatf("tbl%0d pulse", i), 32'(btn_pulse), 32'(tbl[i].ep));
      check($sformatf("tbl%0d level", i), 32'(btn_level), 32'(tbl[i].el));
      check($sformatf("tbl%0d any", i),   32'(btn_any),   32'(tbl[i].ea));
    end
    go_idle(12);

    // Long hold: auto-repeat on channel 0 only.
    exp_q0[0] = 6;  exp_q0[1] = 16; exp_q0[2] = 19;
    exp_q0[3] = 22; exp_q0[4] = 25; exp_q0[5] = 28;
    q0.delete(); q1.delete();
    for (int i = 0; i < 30; i++) begin
      step(2'b11, 1'b0, "hold");
      if (btn_pulse[0]) q0.push_back(i);
      if (btn_pulse[1]) q1.push_back(i);
    end
    check("repeat count ch0", 32'(q0.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < q0.size()) check($sformatf("repeat edge %0d", i), 32'(q0[i]), 32'(exp_q0[i]));
    check("repeat count ch1", 32'(q1.size()), 32'd1);
    if (q1.size() > 0) check("ch1 pulse edge", 32'(q1[0]), 32'd6);
    go_idle(12);

    // Short glitchy press is never accepted.
    seen_pulse = 1'b0; seen_level = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step((i < 3 || (i >= 4 && i < 7)) ? 2'b01 : 2'b00, 1'b0, "glitch");
      seen_pulse |= btn_pulse[0];
      seen_level |= btn_level[0];
    end
    check("glitch pulse", 32'(seen_pulse), 32'd0);
    check("glitch level", 32'(seen_level), 32'd0);

    // Release bounce keeps level, then a long release drops it 2+DB cycles later.
    seen_pulse = 1'b0;
    for (int i = 0; i < 27; i++) begin
      step((i < 9 || (i >= 11 && i < 16)) ? 2'b01 : 2'b00, 1'b0, "bounce");
      if (i > 6) seen_pulse |= btn_pulse[0];
      if (i == 6)  check("bounce accept", 32'(btn_pulse[0]), 32'd1);
      if (i == 14) check("bounce level kept", 32'(btn_level[0]), 32'd1);
      if (i == 21) check("release level before", 32'(btn_level[0]), 32'd1);
      if (i == 22) check("release level after", 32'(btn_level[0]), 32'd0);
    end
    check("bounce no pulse", 32'(seen_pulse), 32'd0);
    go_idle(4);

    // Reset mid-press restarts the debounce.
    seen_pulse = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(2'b01, (i == 5), "midreset");
      if (i < 12) seen_pulse |= btn_pulse[0];
      if (i == 12) check("midreset pulse", 32'(btn_pulse[0]), 32'd1);
    end
    check("midreset early pulse", 32'(seen_pulse), 32'd0);
    go_idle(12);

    // Randomized stimulus with varying toggle density.
    begin
      logic [NB-1:0] b;
      int            den;
      b = '0;
      den = 4;
      for (int i = 0; i < 3000; i++) begin
        if (i % 200 == 0) den = $urandom_range(2, 40);
        for (int c = 0; c < NB; c++)
          if ($urandom_range(0, den - 1) == 0) b[c] = ~b[c];
        step(b, ($urandom_range(0, 399) == 0), "random");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
